// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of an asynchronous PWM input and reports duty in percent.
// A restoring divider yields one quotient bit per cycle; a no-edge timeout forces 0% or 100%.
module pwm_duty_decoder #(
    parameter int unsigned      CNT_W   = 21,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(1_000_000)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PWM_IN,
    output logic [CNT_W-1:0] PERIOD,
    output logic [CNT_W-1:0] HIGH_TIME,
    output logic [6:0]       DUTY,
    output logic             VALID,
    output logic             BUSY,
    output logic             STALL
);
    localparam int unsigned      QW         = CNT_W + 7;
    localparam int unsigned      IW         = $clog2(QW);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = TIMEOUT - CNT_W'(1);

    typedef enum logic {StIdle, StDiv} state_e;

    state_e           state_q;
    logic             sync1_q, sync2_q, sync2_prev_q;
    logic             armed_q, pend_q;
    logic [CNT_W-1:0] cnt_q, hacc_q;
    logic [CNT_W-1:0] divisor_q, rem_q;
    logic [QW-1:0]    quo_q;
    logic [IW-1:0]    iter_q;

    logic             rise, capture, timeout_hit, last_iter;
    logic [CNT_W:0]   trial;
    logic             trial_ge;
    logic [CNT_W-1:0] rem_next;
    logic [QW-1:0]    quo_next, dividend;
    logic [6:0]       duty_clamped;

    always_comb begin
        rise        = sync2_q & ~sync2_prev_q;
        capture     = rise & armed_q;
        // cnt saturates at TIMEOUT, so this fires exactly once per stall
        timeout_hit = ~rise & (cnt_q == TIMEOUT_M1);
        last_iter   = (iter_q == IW'(QW - 1));
        trial       = {rem_q, quo_q[QW-1]};
        trial_ge    = (trial >= {1'b0, divisor_q});
        rem_next    = trial_ge ? CNT_W'(trial - {1'b0, divisor_q}) : trial[CNT_W-1:0];
        quo_next    = {quo_q[QW-2:0], trial_ge};
        dividend    = QW'(HIGH_TIME) * QW'(7'd100);
        duty_clamped = (quo_next > QW'(100)) ? 7'd100 : quo_next[6:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            sync2_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            hacc_q       <= '0;
            divisor_q    <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            state_q      <= StIdle;
            PERIOD       <= '0;
            HIGH_TIME    <= '0;
            DUTY         <= '0;
            VALID        <= 1'b0;
            BUSY         <= 1'b0;
            STALL        <= 1'b0;
        end else begin
            sync1_q      <= PWM_IN;
            sync2_q      <= sync1_q;
            sync2_prev_q <= sync2_q;
            VALID        <= 1'b0;

            if (rise) begin
                cnt_q  <= CNT_W'(1);
                hacc_q <= CNT_W'(1);
            end else if (cnt_q != TIMEOUT) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                hacc_q <= hacc_q + CNT_W'(sync2_q);
            end

            if (timeout_hit) begin
                PERIOD    <= '0;
                HIGH_TIME <= '0;
                DUTY      <= sync2_q ? 7'd100 : 7'd0;
                VALID     <= 1'b1;
                STALL     <= 1'b1;
                BUSY      <= 1'b0;
                armed_q   <= 1'b0;
                pend_q    <= 1'b0;
                state_q   <= StIdle;
            end else begin
                if (rise) begin
                    armed_q <= 1'b1;
                end
                if (capture) begin
                    PERIOD    <= cnt_q;
                    HIGH_TIME <= hacc_q;
                end
                unique case (state_q)
                    StIdle: begin
                        pend_q <= capture;
                        // Load from the registered outputs: always the latest completed capture
                        if (pend_q) begin
                            quo_q     <= dividend;
                            rem_q     <= '0;
                            divisor_q <= PERIOD;
                            iter_q    <= '0;
                            BUSY      <= 1'b1;
                            state_q   <= StDiv;
                        end
                    end
                    StDiv: begin
                        pend_q <= pend_q | capture;
                        quo_q  <= quo_next;
                        rem_q  <= rem_next;
                        iter_q <= iter_q + IW'(1);
                        if (last_iter) begin
                            DUTY    <= duty_clamped;
                            VALID   <= 1'b1;
                            BUSY    <= 1'b0;
                            STALL   <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized/directed bench for pwm_duty_decoder with an edge-timestamp reference model
// feeding a scoreboard queue that a VALID-driven monitor drains.
`timescale 1ns/1ps
module tb_pwm_duty_decoder;
    localparam int unsigned CNT_W = 21;
    localparam int unsigned TMO   = 4500;
    localparam int unsigned QW    = CNT_W + 7;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             PWM_IN = 1'b0;
    logic [CNT_W-1:0] PERIOD, HIGH_TIME;
    logic [6:0]       DUTY;
    logic             VALID, BUSY, STALL;

    typedef struct {
        int unsigned cyc;
        int unsigned duty;
        int unsigned period;
        int unsigned high;
        bit          stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_busy = 1'b0;

    pwm_duty_decoder #(
        .CNT_W  (CNT_W),
        .TIMEOUT(21'(TMO))
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .PWM_IN   (PWM_IN),
        .PERIOD   (PERIOD),
        .HIGH_TIME(HIGH_TIME),
        .DUTY     (DUTY),
        .VALID    (VALID),
        .BUSY     (BUSY),
        .STALL    (STALL)
    );

    always #5 CLK = ~CLK;

    // Reference model: edge timestamps, high-sample counts and a divider that is free or busy
    // until a known completion cycle.
    int unsigned m_cyc = 0, last_edge = 1, hi_cnt = 0;
    int unsigned lat_p = 0, lat_h = 0, prev_p = 0, prev_h = 0;
    int unsigned div_p = 1, div_h = 0, done_at = 0, dq = 0;
    bit ph1 = 0, ph2 = 0, ph3 = 0, s_m = 0, e_m = 0, cap_m = 0;
    bit armed_m = 0, timed_out_m = 0, pend_m = 0, old_pend = 0, active_m = 0;

    task automatic push_exp(input int unsigned d, input int unsigned p, input int unsigned h,
                            input bit st);
        exp_t x;
        x.cyc = m_cyc;
        x.duty = d;
        x.period = p;
        x.high = h;
        x.stall = st;
        exp_q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RST_N);
            if (!RST_N) begin
                m_cyc = 0; last_edge = 1; hi_cnt = 0; lat_p = 0; lat_h = 0;
                ph1 = 0; ph2 = 0; ph3 = 0;
                armed_m = 0; timed_out_m = 0; pend_m = 0; active_m = 0;
                exp_q.delete();
            end else begin
                m_cyc++;
                s_m = ph2;
                e_m = ph2 && !ph3;
                ph3 = ph2; ph2 = ph1; ph1 = PWM_IN;
                old_pend = pend_m;
                prev_p = lat_p;
                prev_h = lat_h;
                if (!e_m && !timed_out_m && (m_cyc - last_edge + 1 == TMO)) begin
                    timed_out_m = 1; armed_m = 0; pend_m = 0; active_m = 0;
                    lat_p = 0; lat_h = 0;
                    push_exp(s_m ? 100 : 0, 0, 0, 1'b1);
                end else begin
                    cap_m = e_m && armed_m;
                    if (e_m) begin
                        if (armed_m) begin
                            lat_p = m_cyc - last_edge;
                            lat_h = hi_cnt;
                        end
                        armed_m = 1; timed_out_m = 0; last_edge = m_cyc; hi_cnt = 1;
                    end else begin
                        hi_cnt += 32'(s_m);
                    end
                    if (active_m && m_cyc == done_at) begin
                        dq = (div_h * 100) / div_p;
                        if (dq > 100) dq = 100;
                        push_exp(dq, lat_p, lat_h, 1'b0);
                        active_m = 0;
                        pend_m = old_pend || cap_m;
                    end else if (!active_m && old_pend) begin
                        div_p = prev_p; div_h = prev_h;
                        active_m = 1;
                        done_at = m_cyc + QW;
                        pend_m = cap_m;
                    end else begin
                        pend_m = old_pend || cap_m;
                    end
                end
            end
        end
    end

    // Monitor: pops one expectation per VALID, flags late/missing ones and BUSY gaps.
    int   busy_gap = 0;
    exp_t got;
    initial begin
        forever begin
            @(negedge CLK);
            if (RST_N === 1'b1) begin
                if (VALID) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid: cycle %0d duty %0d period %0d, none expected",
                                 m_cyc, DUTY, PERIOD);
                    end else begin
                        got = exp_q.pop_front();
                        if (got.cyc != m_cyc || 32'(DUTY) != got.duty || 32'(PERIOD) != got.period ||
                            32'(HIGH_TIME) != got.high || STALL != got.stall) begin
                            errors++;
                            $display("FAIL result: got cyc %0d duty %0d period %0d high %0d stall %0d; want cyc %0d duty %0d period %0d high %0d stall %0d",
                                     m_cyc, DUTY, PERIOD, HIGH_TIME, STALL,
                                     got.cyc, got.duty, got.period, got.high, got.stall);
                        end
                    end
                end
                if (exp_q.size() != 0 && exp_q[0].cyc < m_cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_valid: expected at cycle %0d duty %0d, now cycle %0d",
                             exp_q[0].cyc, exp_q[0].duty, m_cyc);
                    exp_q.delete(0);
                end
                if (chk_busy) begin
                    if (!BUSY) begin
                        busy_gap++;
                    end else begin
                        if (busy_gap > 0) begin
                            checks++;
                            if (busy_gap > 1) begin
                                errors++;
                                $display("FAIL busy_gap: BUSY low %0d cycles, allowed 1", busy_gap);
                            end
                        end
                        busy_gap = 0;
                    end
                end else begin
                    busy_gap = 0;
                end
            end
        end
    end

    task automatic hold(input bit v, input int n);
        PWM_IN = v;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pulses(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (PERIOD != '0 || HIGH_TIME != '0 || DUTY != '0 || VALID || BUSY || STALL) begin
            errors++;
            $display("FAIL %s: period %0d high %0d duty %0d valid %0d busy %0d stall %0d, want all 0",
                     name, PERIOD, HIGH_TIME, DUTY, VALID, BUSY, STALL);
        end
    endtask

    bit seen_busy;
    initial begin
        RST_N = 1'b0;
        PWM_IN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_zero("reset_state");
        @(posedge CLK);
        #1 RST_N = 1'b1;

        pulses(2000, 2000, 3);
        pulses(3400, 600, 3);
        pulses(1, 3999, 3);
        hold(1'b1, TMO + 200);          // stall high -> 100%
        pulses(100, 100, 4);            // resume; second edge captures
        hold(1'b0, TMO + 200);          // stall low -> 0%
        pulses(50, 50, 3);

        // Period shorter than the divider latency
        pulses(3, 7, 8);
        chk_busy = 1'b1;
        pulses(3, 7, 30);
        chk_busy = 1'b0;

        for (int i = 0; i < 30; i++) begin
            pulses($urandom_range(1, 300), $urandom_range(1, 300), 1);
        end

        // Reset in the middle of a division
        pulses(20, 20, 2);
        PWM_IN = 1'b1;
        seen_busy = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (BUSY) begin
                seen_busy = 1'b1;
                break;
            end
            hold(1'b1, 1);
        end
        checks++;
        if (!seen_busy) begin
            errors++;
            $display("FAIL busy_start: BUSY 0 after 100 cycles, want 1");
        end
        hold(PWM_IN, 10);
        RST_N = 1'b0;
        hold(1'b0, 3);
        @(negedge CLK);
        check_zero("reset_mid_division");
        @(posedge CLK);
        #1 RST_N = 1'b1;
        pulses(100, 100, 4);
        hold(1'b0, 60);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results outstanding, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
PWM_DUTY_DECODER -- requirements
Module: pwm_duty_decoder

Interface
REQ-001 Parameter CNT_W, default 21, sets the width of the period and high-time counters.
REQ-002 Parameter TIMEOUT, default 21'd1_000_000, is the number of cycles with no rising edge before a stall is declared; it SHALL be at most 2^CNT_W-1 and at least 4.
REQ-003 CLK  input  1  system clock (12 MHz).
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 PWM_IN  input  1  asynchronous PWM waveform from a PMOD pin.
REQ-006 PERIOD  output  CNT_W  last measured period in CLK cycles.
REQ-007 HIGH_TIME  output  CNT_W  last measured high time in CLK cycles.
REQ-008 DUTY  output  7  duty cycle in percent, range 0..100, floor-rounded.
REQ-009 VALID  output  1  one-cycle strobe when DUTY is updated.
REQ-010 BUSY  output  1  high while the divider is iterating.
REQ-011 STALL  output  1  high after a timeout until the next valid measurement.

Function
REQ-012 PWM_IN SHALL pass through a 2-flop synchronizer; a rising edge is the cycle in which sync stage 2 is 1 and its previous value was 0.
REQ-013 Measurement counters: on an edge cycle, set cnt=1 and hacc=1; otherwise cnt+=1 and hacc+=sync2. Example: 2 cycles high and 2 low gives period 4, high 2.
REQ-014 The first rising edge after reset or timeout SHALL only arm the measurer, with no capture.
REQ-015 On each armed rising edge, capture PERIOD<=cnt and HIGH_TIME<=hacc on that clock, and raise a pending request.
REQ-016 When idle with a request pending, the divider SHALL load HIGH_TIME*100 (CNT_W+7 bits) and PERIOD, clear the pending request, and assert BUSY on the next cycle.
REQ-017 Divider: restoring, one quotient bit per cycle, CNT_W+7 iterations.
REQ-018 After the last iteration, DUTY SHALL be registered with VALID high for exactly one cycle, and BUSY SHALL deassert in the same cycle.
REQ-019 Total latency from the capture clock to VALID SHALL be CNT_W+8 cycles.
REQ-020 Captures during BUSY SHALL update PERIOD/HIGH_TIME but not restart the divider. On completion, any pending request SHALL start a new division with the latest values, so the divider always makes progress.
REQ-021 Divide-by-zero is impossible because a captured PERIOD is at least 2. The quotient SHALL be clamped to 100 defensively.
REQ-022 Timeout: when cnt reaches TIMEOUT with no rising edge:
  - PERIOD<=0, HIGH_TIME<=0;
  - DUTY<=100 if sync2=1, else 0;
  - VALID pulses for one cycle and STALL<=1;
  - measurer disarms, any pending request is cleared, and an in-progress division is aborted (BUSY<=0);
  - cnt holds at TIMEOUT and never wraps.
REQ-023 STALL SHALL clear on the next divider-completion VALID.
REQ-024 If a timeout and a divider completion coincide, the timeout result SHALL win.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 While RST_N=0, all state SHALL clear immediately: PERIOD=0, HIGH_TIME=0, DUTY=0, VALID=0, BUSY=0, STALL=0, measurer disarmed, synchronizer=0, no pending request.
REQ-027 Reset during a division SHALL abandon it with no VALID. Operation resumes on the first CLK after RST_N rises, requiring two rising edges before the next capture.

Verification
REQ-028 2000 cycles high / 2000 low, repeated -> PERIOD=4000, HIGH_TIME=2000, DUTY=50, with VALID 29 cycles after each capture.
REQ-029 3400 high / 600 low -> DUTY=85; 1 high / 3999 low -> DUTY=0, HIGH_TIME=1.
REQ-030 With TIMEOUT=1000, hold PWM_IN=1 after running at 50% -> 1000 cycles after the last edge: DUTY=100, PERIOD=0, STALL=1, one VALID. Repeat with PWM_IN held at 0 -> DUTY=0.
REQ-031 Period of 10 cycles, 3 high (shorter than the divider latency) -> VALID every 29-30 cycles, each with DUTY=30, and BUSY never deasserts for more than one cycle.
REQ-032 Pull RST_N low 10 cycles into a division -> no VALID and all outputs 0. After release, the first VALID arrives only after two rising edges plus 29 cycles.
REQ-033 After a stall, resume 50% PWM -> the first edge does not capture, the second edge captures, and STALL clears with DUTY=50.
